pipe_front_regs: RTL
====================

Name: pipe_front_regs

Overview:
- Fetch PC register plus the IF/ID and ID/EX pipeline registers of the 5-stage RV32I core.
- It is the consumer end of the hazard unit's StallF/StallD/FlushD/FlushE/PCSrcE outputs. It applies stalls, inserts bubbles and executes branch redirects.
- It re-presents Rs1E/Rs2E/RdE/ResultSrcE back to the hazard unit.
- It also keeps saturating performance counters for stall, bubble and redirect cycles.

Parameters:
- XLEN, 32, datapath width.
- RESET_PC, 32'h0000_0000, PC value loaded at reset.
- CTRL_W, 8, width of the packed decoded-control bundle carried D->E.
- CNT_W, 32, performance-counter width.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- StallF  in  1  hold PC.
- StallD  in  1  hold IF/ID.
- FlushD  in  1  clear IF/ID.
- FlushE  in  1  clear ID/EX.
- PCSrcE  in  1  branch/jump taken in E.
- PCTargetE  in  XLEN  redirect target.
- InstrF  in  32  instruction from imem at PCF.
- CtrlD  in  CTRL_W  decoded control; bit0 = RegWrite, bit1 = ResultSrc load select.
- Rs1D, Rs2D, RdD  in  5 each  register indices decoded from InstrD.
- RD1D, RD2D, ImmExtD  in  XLEN each  register-file reads and immediate.
- PCF, PCPlus4F  out  XLEN  fetch PC and PC+4.
- InstrD, PCD, PCPlus4D  out  32/XLEN/XLEN  IF/ID contents.
- ValidD, ValidE  out  1  stage holds a real instruction (not a bubble).
- CtrlE  out  CTRL_W  ID/EX control.
- ResultSrcE  out  1  equals CtrlE bit1; drives the hazard unit's load-use check.
- Rs1E, Rs2E, RdE  out  5 each  ID/EX register indices.
- RD1E, RD2E, ImmExtE, PCE, PCPlus4E  out  XLEN each  ID/EX data.
- StallCnt, BubbleCnt, RedirCnt  out  CNT_W each  performance counters.

Behaviour:
- Reset:
  - PCF = RESET_PC.
  - InstrD = NOP (32'h0000_0013); PCD and PCPlus4D = 0; ValidD = 0.
  - All E outputs = 0; ValidE = 0.
  - All counters = 0.
  - rst has priority over every other input.
- PC register:
  - PCSrcE=1 -> PCF <= PCTargetE. PCSrcE overrides StallF, so a redirect is never lost.
  - Else StallF=1 -> hold.
  - Else PCF <= PCF+4, mod 2^XLEN wrap.
  - PCPlus4F = PCF+4, combinational.
- IF/ID register:
  - FlushD=1 -> InstrD=NOP, PCD=0, PCPlus4D=0, ValidD=0. Flush wins over StallD.
  - Else StallD=1 -> hold all fields.
  - Else load InstrF, PCF, PCPlus4F; ValidD=1.
- ID/EX register:
  - FlushE=1 -> all fields 0 and ValidE=0.
  - Zeroed Rs1E/Rs2E/RdE plus CtrlE=0 guarantee no spurious forwarding or load-use stall from a bubble.
  - Else load all D inputs every cycle, and ValidE <= ValidD. There is no stall on E.
- Latency:
  - Redirect: target fetched the cycle after PCSrcE (PCF = target one edge later); two younger instructions are squashed.
  - Load-use: exactly one bubble in E; the D instruction is held one cycle.
- Counters:
  - All saturate at all-ones with no wrap, and are cleared only by rst.
  - StallCnt +1 each cycle StallD=1.
  - BubbleCnt +1 each cycle FlushE=1 and PCSrcE=0 (load-use bubble).
  - RedirCnt +1 each cycle PCSrcE=1.
- Simultaneous and boundary cases:
  - StallD=1 with FlushD=1 -> flush.
  - StallF with PCSrcE -> redirect.
  - rst asserted mid-stall -> reset values next edge; stall inputs ignored that cycle.
  - PCF at 32'hFFFF_FFFC with no stall -> 0.

Decomposition:
- Package pipe_pkg holds:
  - NOP_INSTR constant.
  - CTRL_W default.
  - Control-bundle bit indices (CTRL_REGWRITE=0, CTRL_RESULTSRC=1).
- Sub-module pipe_en_clr_reg: parameterised width and reset/clear value, with sync rst, clr, en. Clr has priority over en. It is instantiated for PC, IF/ID and ID/EX.
- Counters live inline.

Test Plan:
1. Reset then 4 free-run cycles with InstrF stream -> PCF 0,4,8,12; InstrD lags by 1 with ValidD=1; all counters 0.
2. StallF=StallD=1 and FlushE=1 for 1 cycle at PCF=8 -> PCF holds 8; InstrD holds; E zeroed with ValidE=0; StallCnt=1, BubbleCnt=1.
3. PCSrcE=1, PCTargetE=0x100, FlushD=FlushE=1 -> next PCF=0x100; InstrD=0x13, ValidD=0; E zeroed; RedirCnt=1, BubbleCnt unchanged.
4. PCSrcE=1 with StallF=1 and StallD=1, FlushD=1 -> PCF=target; IF/ID flushed, not held.
5. Force StallD=1 for 2^CNT_W+3 cycles (CNT_W overridden to 4) -> StallCnt saturates at 4'hF.
6. Assert rst mid-stall with non-zero counters -> next edge: PCF=RESET_PC, InstrD=NOP, all counters 0.

Source files
------------

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_pkg
// Purpose  : Shared constants for the front-end pipeline registers of the
//            5-stage RV32I core (fetch PC, IF/ID, ID/EX).
// Contents : NOP_INSTR       - canonical NOP (addi x0,x0,0) used for bubbles
//            CTRL_W_DEFAULT  - default width of the decoded-control bundle
//            CTRL_REGWRITE   - bit index of RegWrite inside the bundle
//            CTRL_RESULTSRC  - bit index of the load result-select bit
// Revision : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  localparam logic [31:0] NOP_INSTR      = 32'h0000_0013;
  localparam int          CTRL_W_DEFAULT = 8;
  localparam int          CTRL_REGWRITE  = 0;
  localparam int          CTRL_RESULTSRC = 1;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_en_clr_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_en_clr_reg
// Purpose  : Generic pipeline register with synchronous reset, synchronous
//            clear and load enable. Priority: rst > clr > en > hold.
//            Reset and clear both load CLR_VAL, so a flushed stage looks
//            exactly like a freshly reset one.
// Ports    : clk  - clock, rising edge
//            rst  - synchronous active-high reset
//            clr  - synchronous clear (flush), beats en
//            en   - load d when set, otherwise hold
//            d    - next value
//            q    - registered value
// Revision : 1.0 - initial release
// ============================================================================
module pipe_en_clr_reg #(
  parameter int           W       = 32,
  parameter logic [W-1:0] CLR_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] val_q;
  logic [W-1:0] val_d;

  always_comb begin
    val_d = val_q;
    if (clr) begin
      val_d = CLR_VAL;
    end else if (en) begin
      val_d = d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      val_q <= CLR_VAL;
    end else begin
      val_q <= val_d;
    end
  end

  assign q = val_q;

endmodule : pipe_en_clr_reg
`default_nettype wire

// File: rtl/pipe_front_regs.sv
`default_nettype none
// ============================================================================
// Module   : pipe_front_regs
// Purpose  : Fetch PC register plus IF/ID and ID/EX pipeline registers.
//            Applies the hazard unit's stall/flush/redirect controls and
//            keeps saturating stall, bubble and redirect counters.
// Ports    : clk, rst                  - clock, sync active-high reset
//            StallF, StallD            - hold PC / hold IF/ID
//            FlushD, FlushE            - clear IF/ID / clear ID/EX
//            PCSrcE, PCTargetE         - taken branch/jump and its target
//            InstrF                    - instruction fetched at PCF
//            CtrlD, Rs1D, Rs2D, RdD    - decoded control and register indices
//            RD1D, RD2D, ImmExtD       - register reads and immediate
//            PCF, PCPlus4F             - fetch PC and PC+4
//            InstrD, PCD, PCPlus4D     - IF/ID contents, ValidD
//            CtrlE .. PCPlus4E, ValidE - ID/EX contents, ResultSrcE
//            StallCnt, BubbleCnt, RedirCnt - saturating performance counters
// Revision : 1.0 - initial release
// ============================================================================
module pipe_front_regs
  import pipe_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              CTRL_W   = CTRL_W_DEFAULT,
  parameter int              CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              StallF,
  input  logic              StallD,
  input  logic              FlushD,
  input  logic              FlushE,
  input  logic              PCSrcE,
  input  logic [XLEN-1:0]   PCTargetE,
  input  logic [31:0]       InstrF,
  input  logic [CTRL_W-1:0] CtrlD,
  input  logic [4:0]        Rs1D,
  input  logic [4:0]        Rs2D,
  input  logic [4:0]        RdD,
  input  logic [XLEN-1:0]   RD1D,
  input  logic [XLEN-1:0]   RD2D,
  input  logic [XLEN-1:0]   ImmExtD,
  output logic [XLEN-1:0]   PCF,
  output logic [XLEN-1:0]   PCPlus4F,
  output logic [31:0]       InstrD,
  output logic [XLEN-1:0]   PCD,
  output logic [XLEN-1:0]   PCPlus4D,
  output logic              ValidD,
  output logic              ValidE,
  output logic [CTRL_W-1:0] CtrlE,
  output logic              ResultSrcE,
  output logic [4:0]        Rs1E,
  output logic [4:0]        Rs2E,
  output logic [4:0]        RdE,
  output logic [XLEN-1:0]   RD1E,
  output logic [XLEN-1:0]   RD2E,
  output logic [XLEN-1:0]   ImmExtE,
  output logic [XLEN-1:0]   PCE,
  output logic [XLEN-1:0]   PCPlus4E,
  output logic [CNT_W-1:0]  StallCnt,
  output logic [CNT_W-1:0]  BubbleCnt,
  output logic [CNT_W-1:0]  RedirCnt
);

  localparam int IFID_W = 32 + 2 * XLEN + 1;
  localparam int IDEX_W = CTRL_W + 15 + 5 * XLEN + 1;

  // A flushed IF/ID carries a NOP with zero PCs and the valid bit cleared.
  localparam logic [IFID_W-1:0] IFID_CLR = {NOP_INSTR, {(2 * XLEN + 1){1'b0}}};

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W - 1){1'b0}}, 1'b1};

  // --------------------------------------------------------------------------
  // PC register: a redirect must load even while fetch is stalled, otherwise
  // the taken branch would be lost.
  // --------------------------------------------------------------------------
  logic            pc_en;
  logic [XLEN-1:0] pc_next;

  assign PCPlus4F = PCF + XLEN'(4);
  assign pc_en    = PCSrcE | ~StallF;
  assign pc_next  = PCSrcE ? PCTargetE : PCPlus4F;

  pipe_en_clr_reg #(
    .W       (XLEN),
    .CLR_VAL (RESET_PC)
  ) u_pc_reg (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .en  (pc_en),
    .d   (pc_next),
    .q   (PCF)
  );

  // --------------------------------------------------------------------------
  // IF/ID register
  // --------------------------------------------------------------------------
  logic [IFID_W-1:0] ifid_d;
  logic [IFID_W-1:0] ifid_q;

  assign ifid_d = {InstrF, PCF, PCPlus4F, 1'b1};

  pipe_en_clr_reg #(
    .W       (IFID_W),
    .CLR_VAL (IFID_CLR)
  ) u_ifid_reg (
    .clk (clk),
    .rst (rst),
    .clr (FlushD),
    .en  (~StallD),
    .d   (ifid_d),
    .q   (ifid_q)
  );

  assign {InstrD, PCD, PCPlus4D, ValidD} = ifid_q;

  // --------------------------------------------------------------------------
  // ID/EX register. A bubble zeroes the register indices and the control
  // bundle, so it can neither forward nor trigger a load-use stall.
  // --------------------------------------------------------------------------
  logic [IDEX_W-1:0] idex_d;
  logic [IDEX_W-1:0] idex_q;

  assign idex_d = {CtrlD, Rs1D, Rs2D, RdD, RD1D, RD2D, ImmExtD, PCD, PCPlus4D, ValidD};

  pipe_en_clr_reg #(
    .W       (IDEX_W),
    .CLR_VAL ('0)
  ) u_idex_reg (
    .clk (clk),
    .rst (rst),
    .clr (FlushE),
    .en  (1'b1),
    .d   (idex_d),
    .q   (idex_q)
  );

  assign {CtrlE, Rs1E, Rs2E, RdE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, ValidE} = idex_q;
  assign ResultSrcE = CtrlE[CTRL_RESULTSRC];

  // --------------------------------------------------------------------------
  // Saturating performance counters. FlushE during a redirect is branch
  // squashing, not a load-use bubble, so it is excluded from BubbleCnt.
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] stall_cnt_q,  stall_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
  logic [CNT_W-1:0] redir_cnt_q,  redir_cnt_d;

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    redir_cnt_d  = redir_cnt_q;
    if (StallD && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
    if (FlushE && !PCSrcE && (bubble_cnt_q != CNT_MAX)) begin
      bubble_cnt_d = bubble_cnt_q + CNT_ONE;
    end
    if (PCSrcE && (redir_cnt_q != CNT_MAX)) begin
      redir_cnt_d = redir_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
      redir_cnt_q  <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
      redir_cnt_q  <= redir_cnt_d;
    end
  end

  assign StallCnt  = stall_cnt_q;
  assign BubbleCnt = bubble_cnt_q;
  assign RedirCnt  = redir_cnt_q;

endmodule : pipe_front_regs
`default_nettype wire
